// File: rtl/pcm_decoder.sv
// PCM receive path: deserialises frame-synced 8-bit codes (MSB first) and expands them to
// 13-bit sign-magnitude samples behind a one-code pending buffer. Option: PCM_DEC_MIDPOINT_EN.
module pcm_decoder #(
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        bit_en,
    input  logic        fs,
    input  logic        sdi,
    input  logic        out_ready,
    input  logic        err_clr,
    output logic [12:0] data_out,
    output logic        out_valid,
    output logic        overflow,
    output logic        sync_err
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

`ifdef PCM_DEC_MIDPOINT_EN
    localparam logic RND = 1'b1;
`else
    localparam logic RND = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(7);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       shift_q;

    logic [7:0]  code_q,  code_d;
    logic        pend_q,  pend_d;
    logic [12:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        ovf_q,   ovf_d;
    logic        serr_q,  serr_d;

    logic [7:0] new_code;
    logic       code_done;
    logic       sync_hit;
    logic       xfer;
    logic       load;
    logic       drop;

    // Segment expansion: segment k sets the implied leading one at bit k+4 (none for k=0).
    function automatic logic [12:0] expand(input logic [7:0] code);
        logic [2:0]  k;
        logic [11:0] q_ext;
        logic [11:0] mag;
        k     = code[6:4];
        q_ext = {8'b0, code[3:0]};
        if (k == 3'd0) begin
            mag = {7'b0, code[3:0], RND};
        end else begin
            mag = (12'd1 << ({1'b0, k} + 4'd4)) | (q_ext << k) | ({11'b0, RND} << (k - 3'd1));
        end
        return {code[7], mag};
    endfunction

    assign new_code  = {shift_q[6:0], sdi};
    assign code_done = (state_q == SHIFT) && bit_en && !fs && (cnt_q == LAST_BIT);
    assign sync_hit  = (state_q == SHIFT) && bit_en && fs;
    assign xfer      = pend_q && (!valid_q || out_ready);
    // A completion only fits if the pending slot is empty or is being drained this edge.
    assign load      = code_done && (!pend_q || xfer);
    assign drop      = code_done && pend_q && !xfer;

    // NOTE: sequential state is updated with non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bit_en && fs) begin
                        shift_q <= new_code;
                        cnt_q   <= CNT_W'(1);
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (fs) begin
                            // Resynchronise: this bit becomes the sign bit of a fresh code.
                            shift_q <= {7'b0, sdi};
                            cnt_q   <= CNT_W'(1);
                        end else if (cnt_q == LAST_BIT) begin
                            shift_q <= new_code;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            shift_q <= new_code;
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // NOTE: every variable driven here gets its hold value first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        code_d  = code_q;
        pend_d  = pend_q;
        data_d  = data_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        serr_d  = serr_q;

        if (xfer) begin
            data_d  = expand(code_q);
            valid_d = 1'b1;
            pend_d  = 1'b0;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end

        if (load) begin
            code_d = new_code;
            pend_d = 1'b1;
        end

        if (err_clr) begin
            ovf_d  = 1'b0;
            serr_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (sync_hit) begin
            serr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q  <= '0;
            pend_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            code_q  <= code_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            serr_q  <= serr_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign overflow  = ovf_q;
    assign sync_err  = serr_q;

endmodule

// File: tb/tb_pcm_decoder.sv
// Directed bench for pcm_decoder: serial frames in, expanded samples checked against
// hand-computed constants (selected by PCM_DEC_MIDPOINT_EN).
module tb_pcm_decoder;

`ifdef PCM_DEC_MIDPOINT_EN
    localparam logic [12:0] E_00 = 13'h0001;
    localparam logic [12:0] E_1A = 13'h0035;
    localparam logic [12:0] E_C5 = 13'h1158;
    localparam logic [12:0] E_FF = 13'h1FC0;
    localparam logic [12:0] E_80 = 13'h1001;
    localparam logic [12:0] E_10 = 13'h0021;
    localparam logic [12:0] E_7F = 13'h0FC0;
    localparam logic [12:0] E_4B = 13'h01B8;
`else
    localparam logic [12:0] E_00 = 13'h0000;
    localparam logic [12:0] E_1A = 13'h0034;
    localparam logic [12:0] E_C5 = 13'h1150;
    localparam logic [12:0] E_FF = 13'h1F80;
    localparam logic [12:0] E_80 = 13'h1000;
    localparam logic [12:0] E_10 = 13'h0020;
    localparam logic [12:0] E_7F = 13'h0F80;
    localparam logic [12:0] E_4B = 13'h01B0;
`endif

    logic        clk;
    logic        rst_n;
    logic        bit_en;
    logic        fs;
    logic        sdi;
    logic        out_ready;
    logic        err_clr;
    logic [12:0] data_out;
    logic        out_valid;
    logic        overflow;
    logic        sync_err;

    int n_checks;
    int n_errors;
    int valid_cycles;
    logic [12:0] got_q[$];

    pcm_decoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .fs        (fs),
        .sdi       (sdi),
        .out_ready (out_ready),
        .err_clr   (err_clr),
        .data_out  (data_out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .sync_err  (sync_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record every accepted sample and every cycle out_valid is high.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            valid_cycles++;
            if (out_ready) got_q.push_back(data_out);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got_q.size()) return {19'b0, got_q[i]};
        return 32'hDEAD;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic f, input logic d, input int gap);
        bit_en = 1'b1;
        fs     = f;
        sdi    = d;
        tick();
        bit_en = 1'b0;
        fs     = 1'b0;
        sdi    = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] code, input int gap);
        for (int i = 7; i >= 0; i--) send_bit(i == 7, code[i], gap);
    endtask

    task automatic clear_log();
        got_q.delete();
        valid_cycles = 0;
    endtask

    initial begin
        logic [7:0] c5;
        logic [7:0] ff;
        logic [7:0] k4b;
        c5  = 8'hC5;
        ff  = 8'hFF;
        k4b = 8'h4B;
        n_checks = 0;
        n_errors = 0;
        valid_cycles = 0;
        rst_n = 1'b0;
        bit_en = 1'b0;
        fs = 1'b0;
        sdi = 1'b0;
        out_ready = 1'b0;
        err_clr = 1'b0;
        repeat (3) tick();
        check("rst_data", data_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_serr", sync_err, 0);
        rst_n = 1'b1;
        tick();

        // Reset mid-frame while a sample is held: everything clears, partial code is lost.
        send_frame(8'h1A, 0);
        tick();
        check("hold_before_rst_valid", out_valid, 1);
        check("hold_before_rst_data", data_out, E_1A);
        for (int i = 7; i >= 4; i--) send_bit(i == 7, ff[i], 0);
        rst_n = 1'b0;
        #2;
        check("midrst_data", data_out, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_serr", sync_err, 0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 3; i >= 0; i--) send_bit(1'b0, ff[i], 0);
        repeat (2) tick();
        check("partial_lost_valid", out_valid, 0);
        out_ready = 1'b1;
        send_frame(8'hFF, 0);
        check("lat_edge_n_valid", out_valid, 0);
        tick();
        check("lat_edge_n1_valid", out_valid, 1);
        check("lat_edge_n1_data", data_out, E_FF);
        tick();
        check("ff_drop_valid", out_valid, 0);
        check("ff_data_held", data_out, E_FF);

        // Back-to-back frames, bit_en every third cycle, consumer always ready.
        clear_log();
        send_frame(8'h00, 2);
        send_frame(8'h1A, 2);
        send_frame(8'hC5, 2);
        repeat (3) tick();
        check("b2b_count", got_q.size(), 3);
        check("b2b_0", got_at(0), E_00);
        check("b2b_1", got_at(1), E_1A);
        check("b2b_2", got_at(2), E_C5);
        check("b2b_valid_cycles", valid_cycles, 3);
        check("b2b_ovf", overflow, 0);

        // Segment boundaries.
        clear_log();
        send_frame(8'h80, 0);
        send_frame(8'h10, 0);
        send_frame(8'h7F, 0);
        repeat (3) tick();
        check("seg_count", got_q.size(), 3);
        check("seg_80", got_at(0), E_80);
        check("seg_10", got_at(1), E_10);
        check("seg_7F", got_at(2), E_7F);

        // Backpressure: one held, one pending, third dropped.
        out_ready = 1'b0;
        send_frame(8'h1A, 0);
        send_frame(8'hC5, 0);
        send_frame(8'hFF, 0);
        tick();
        check("bp_ovf", overflow, 1);
        check("bp_valid", out_valid, 1);
        check("bp_data", data_out, E_1A);
        clear_log();
        out_ready = 1'b1;
        repeat (3) tick();
        check("bp_count", got_q.size(), 2);
        check("bp_first", got_at(0), E_1A);
        check("bp_second", got_at(1), E_C5);
        check("bp_valid_drop", out_valid, 0);
        check("bp_ovf_sticky", overflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("bp_ovf_clr", overflow, 0);

        // fs at bit 5 of a frame: resync onto a full 0xC5.
        clear_log();
        send_bit(1'b1, 1'b1, 0);
        send_bit(1'b0, 1'b0, 0);
        send_frame(8'hC5, 0);
        repeat (3) tick();
        check("sync_serr", sync_err, 1);
        check("sync_count", got_q.size(), 1);
        check("sync_sample", got_at(0), E_C5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("sync_clr", sync_err, 0);

        // err_clr on the same edge as a new sync error: set wins.
        clear_log();
        send_bit(1'b1, 1'b1, 0);
        err_clr = 1'b1;
        send_bit(1'b1, k4b[7], 0);
        err_clr = 1'b0;
        check("set_wins_serr", sync_err, 1);
        for (int i = 6; i >= 0; i--) send_bit(1'b0, k4b[i], 0);
        repeat (3) tick();
        check("resync_sample", got_at(0), E_4B);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("set_wins_clr", sync_err, 0);

        // Completion on the same edge the held sample is accepted, with a code pending.
        out_ready = 1'b0;
        clear_log();
        send_frame(8'h00, 0);
        send_frame(8'h1A, 0);
        tick();
        for (int i = 7; i >= 1; i--) send_bit(i == 7, c5[i], 0);
        out_ready = 1'b1;
        send_bit(1'b0, c5[0], 0);
        check("sim_valid", out_valid, 1);
        check("sim_data", data_out, E_1A);
        check("sim_ovf", overflow, 0);
        repeat (3) tick();
        check("sim_count", got_q.size(), 3);
        check("sim_0", got_at(0), E_00);
        check("sim_1", got_at(1), E_1A);
        check("sim_2", got_at(2), E_C5);
        check("sim_ovf_end", overflow, 0);
        check("sim_valid_end", out_valid, 0);

        // Toggling fs/sdi without bit_en must be ignored.
        clear_log();
        for (int i = 0; i < 20; i++) begin
            fs  = i[0];
            sdi = i[1];
            tick();
        end
        fs  = 1'b0;
        sdi = 1'b0;
        check("noen_count", got_q.size(), 0);
        check("noen_valid", out_valid, 0);
        check("noen_serr", sync_err, 0);
        send_frame(8'h1A, 0);
        repeat (3) tick();
        check("noen_after_count", got_q.size(), 1);
        check("noen_after_sample", got_at(0), E_1A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcm_decoder.md
Name: pcm_decoder

Overview:
- Receive side of the PCM link: deserialises 8-bit PCM codes (frame-sync aligned, MSB first) and expands each code to a 13-bit sign-magnitude linear sample.
- The expansion is the inverse of the team's 13→8 segment compressor: {sign, seg[2:0], q[3:0]}.
- Sits between the serial line interface and the sample consumer (DAC path or FIFO).
- Output side uses a valid/ready handshake, backed by a one-code pending buffer.

Parameters:
CNT_W, 3, width of bit counter (8 bits per frame; fixed at 3, not for override)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
bit_en  input  1  serial bit strobe; fs/sdi are sampled only on clk edges where bit_en=1
fs  input  1  frame sync; high with the first (MSB, sign) bit of a code
sdi  input  1  serial data in, MSB first
out_ready  input  1  consumer accepts data_out this cycle
err_clr  input  1  synchronous clear of overflow and sync_err
data_out  output  13  {sign, magnitude[11:0]} linear sample
out_valid  output  1  data_out holds an unconsumed sample
overflow  output  1  sticky: a completed code was dropped
sync_err  output  1  sticky: fs seen mid-frame

Behaviour:
- Reset (async, rst_n=0): state IDLE, bit counter 0, shift reg 0, code_reg 0, code_pend 0, data_out 0, out_valid 0, overflow 0, sync_err 0.
- FSM states:
  - IDLE: on bit_en&fs, shift in sdi, cnt=1, go to SHIFT. Ignore bit_en&!fs.
  - SHIFT: on bit_en, shift sdi in (MSB first) and cnt++.
    - On the 8th bit (cnt==7 before the edge): load code_reg with the complete code and return to IDLE.
    - bit_en&fs while in SHIFT: sync_err<=1, discard partial code, restart with this bit as bit 7, cnt=1, stay in SHIFT.
- Code completion at edge N:
  - code_pend=0: code_reg loads, code_pend<=1.
  - code_pend=1: new code dropped, code_reg unchanged, overflow<=1.
- Transfer from pending buffer to output: on any edge with code_pend=1 and (out_valid=0 or out_ready=1), do data_out<=expand(code_reg), out_valid<=1, code_pend<=0.
- Latency: out_valid rises at edge N+1 when the output register is free.
- Output handshake:
  - out_valid&out_ready with no transfer that edge: out_valid<=0, data_out holds its last value.
  - data_out is stable while out_valid=1 and out_ready=0.
- Simultaneous events at the same edge: completion plus transfer means the transfer uses the old code_reg, the new code loads, and code_pend stays 1 (no overflow).
- err_clr clears overflow and sync_err. If a set condition occurs at the same edge, set wins.
- expand(code):
  - s=code[7], k=code[6:4], q=code[3:0].
  - k=0: mag = q<<1 | r0.
  - k=1..7: mag = (1<<(k+4)) | (q<<k) | (r<<(k-1)).
  - r = 1 if midpoint is enabled (see Optional Feature), else 0. r0 = r.
  - data_out = {s, mag[11:0]}. The decode is purely combinational into the registered output.
- Reset asserted mid-frame or mid-handshake: immediate clear of all state; the partial code and any pending sample are lost.

Optional Feature:
- Macro PCM_DEC_MIDPOINT_EN.
  - Defined: r=1, i.e. reconstruction at the midpoint of each quantisation step.
  - Undefined: r=0, i.e. reconstruction at the step's lower bound (exact inverse of the compressor's truncation).
- No other behaviour changes.

Test Plan:
- Reset mid-SHIFT after 4 bits: all outputs 0. Then send frame 0xFF → out_valid at N+1, data_out=0x1FC0 (0x1F80 without midpoint).
- Frames 0x00, 0x1A, 0xC5 back-to-back, out_ready=1, bit_en every 3rd cycle → 0x0001, 0x0035, 0x1158 (without midpoint: 0x0000, 0x0034, 0x1150), each held one cycle, no overflow.
- out_ready=0, send 0x1A then 0xC5 then 0xFF:
  - data_out=0x0035 held; 0xC5 pending; 0xFF dropped, overflow=1.
  - Raise out_ready: 0x0035 then 0x1158, out_valid drops.
- fs pulsed at bit 5 of a frame, then a full 0xC5 → sync_err=1, only 0x1158 output. err_clr → sync_err=0.
- Code completion on the same edge as out_ready accepts a held sample, with code_pend=1 → no overflow, both samples delivered in order.
- bit_en=0 with fs/sdi toggling → no state change, no output.
